// File: rtl/hazard_pkg.sv
// Shared hazard-scoreboard definitions: stall-cause encoding and default register-index width.
package hazard_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_RAW_RS1,
    CAUSE_RAW_RS2,
    CAUSE_WAW,
    CAUSE_FULL
  } stall_cause_e;

endpackage

// File: rtl/hazard_match.sv
// Checks one register index against the pending vector.
// A same-cycle writeback of that register cancels the hazard.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                     enable,
  input  logic [REG_ADDR_W-1:0]    idx,
  input  logic [2**REG_ADDR_W-1:0] pending,
  input  logic                     wb_valid,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  output logic                     hit
);

  logic wb_hit;

  assign wb_hit = wb_valid && (wb_rd == idx) && (idx != '0);
  assign hit    = enable && (idx != '0) && pending[idx] && !wb_hit;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks long-latency results per register and stalls ID on RAW, WAW or a full scoreboard.
// Define HAZARD_SCOREBOARD_PERF_EN to add the saturating stall_cycles counter output.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
  parameter int MAX_PENDING = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_is_long,
  input  logic                     flush,
  input  logic                     wb_valid,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic                     wb_is_long,
  output logic                     stall,
  output logic [2**REG_ADDR_W-1:0] pending,
  output logic [3:0]               outstanding
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int NREG = 2**REG_ADDR_W;

  logic            rs1_hit, rs2_hit, rd_hit;
  logic            full, issue, long_issue, long_wb;
  stall_cause_e    cause;
  logic [NREG-1:0] pending_next;
  logic [3:0]      outstanding_next;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs1 (
    .enable(id_rs1_used), .idx(id_rs1), .pending(pending),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .hit(rs1_hit)
  );

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs2 (
    .enable(id_rs2_used), .idx(id_rs2), .pending(pending),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .hit(rs2_hit)
  );

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rd (
    .enable(id_reg_write), .idx(id_rd), .pending(pending),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .hit(rd_hit)
  );

  assign long_wb = wb_valid && wb_is_long;
  // A long writeback this cycle frees a slot, so a full scoreboard does not block.
  assign full    = id_is_long && (outstanding == 4'(MAX_PENDING)) && !long_wb;

  always_comb begin
    cause = CAUSE_NONE;
    if (id_valid) begin
      if (rs1_hit)      cause = CAUSE_RAW_RS1;
      else if (rs2_hit) cause = CAUSE_RAW_RS2;
      else if (rd_hit)  cause = CAUSE_WAW;
      else if (full)    cause = CAUSE_FULL;
    end
  end

  assign stall      = (cause != CAUSE_NONE);
  assign issue      = id_valid && !stall && !flush;
  assign long_issue = issue && id_is_long;

  // Clear before set so a same-register issue wins over its writeback.
  always_comb begin
    pending_next = pending;
    if (long_wb)
      pending_next[wb_rd] = 1'b0;
    if (long_issue && id_reg_write && (id_rd != '0))
      pending_next[id_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    outstanding_next = outstanding;
    if (long_issue && !long_wb)
      outstanding_next = outstanding + 4'd1;
    else if (long_wb && !long_issue && (outstanding != 4'd0))
      outstanding_next = outstanding - 4'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      outstanding <= 4'd0;
    end else begin
      pending     <= pending_next;
      outstanding <= outstanding_next;
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cycles <= 32'd0;
    else if (stall && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed scoreboard bench for hazard_scoreboard against a register-busy reference model.
module tb_hazard_scoreboard;

  localparam int W    = 5;
  localparam int NREG = 32;
  localparam int MAXP = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_long, flush;
  logic [W-1:0]    id_rs1, id_rs2, id_rd, wb_rd;
  logic            wb_valid, wb_is_long;
  logic            stall;
  logic [NREG-1:0] pending;
  logic [3:0]      outstanding;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0]     stall_cycles;
`endif

  always #5 clock = ~clock;

  hazard_scoreboard #(.REG_ADDR_W(W), .MAX_PENDING(MAXP)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_long(id_is_long),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_is_long(wb_is_long),
    .stall(stall), .pending(pending), .outstanding(outstanding)
`ifdef HAZARD_SCOREBOARD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic            stall;
    logic [NREG-1:0] pend;
    logic [3:0]      outst;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: which registers await a long result, and how many long ops are in flight.
  bit busy[NREG];
  int model_out;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] v;
    v = '0;
    for (int r = 1; r < NREG; r++) v[r] = busy[r];
    return v;
  endfunction

  function automatic bit bypassed(input int r, input bit wv, input int wr);
    return wv && (wr == r) && (r != 0);
  endfunction

  function automatic bit source_blocked(input bit used, input int r, input bit wv, input int wr);
    return used && (r != 0) && busy[r] && !bypassed(r, wv, wr);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) busy[r] = 0;
    model_out = 0;
  endtask

  task automatic apply_stimulus(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                                input int rd, input bit rw, input bit lng, input bit fl,
                                input bit wv, input int wr, input bit wl);
    exp_t e;
    bit   st;
    bit   issued;
    bit   long_done;
    @(posedge clock);
    #1;
    id_valid = v;  id_rs1 = W'(rs1); id_rs1_used = u1; id_rs2 = W'(rs2); id_rs2_used = u2;
    id_rd = W'(rd); id_reg_write = rw; id_is_long = lng; flush = fl;
    wb_valid = wv; wb_rd = W'(wr); wb_is_long = wl;

    long_done = wv && wl;
    st = 0;
    if (v) begin
      if (source_blocked(u1, rs1, wv, wr)) st = 1;
      if (source_blocked(u2, rs2, wv, wr)) st = 1;
      if (source_blocked(rw, rd, wv, wr))  st = 1;
      if (lng && (model_out == MAXP) && !long_done) st = 1;
    end
    e.stall = st;
    e.pend  = model_pending();
    e.outst = 4'(model_out);
    exp_q.push_back(e);

    issued = v && !st && !fl;
    if (long_done) busy[wr] = 0;
    if (issued && lng && rw && (rd != 0)) busy[rd] = 1;
    busy[0] = 0;
    if (issued && lng && !long_done) model_out++;
    else if (long_done && !(issued && lng) && (model_out > 0)) model_out--;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = '0; id_rs1_used = 0; id_rs2 = '0; id_rs2_used = 0;
    id_rd = '0; id_reg_write = 0; id_is_long = 0; flush = 0;
    wb_valid = 0; wb_rd = '0; wb_is_long = 0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    idle_inputs();
    reset = 1;
    #1;
    check_output("reset_pending", pending, 32'h0);
    check_output("reset_outstanding", 32'(outstanding), 32'h0);
    check_output("reset_stall", 32'(stall), 32'h0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  // Monitor: every cycle the DUT presents a stall decision and its tracking state.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output("stall", 32'(stall), 32'(e.stall));
      check_output("pending", pending, e.pend);
      check_output("outstanding", 32'(outstanding), 32'(e.outst));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_list[$];
    int wr;
    idle_inputs();
    model_clear();
    reset = 1;
    #12;
    reset = 0;

    // Load x5, dependent reader stalls until the x5 writeback cycle.
    apply_stimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 5, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Long op to x0 counts as outstanding but never marks x0 busy.
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

    // Fill the scoreboard, then a fifth load stalls unless a long writeback frees a slot.
    for (int i = 1; i <= 4; i++) apply_stimulus(1, 0, 0, 0, 0, i, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 6, 1, 1, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Issue and writeback of x7 in the same cycle: the new issue keeps x7 busy.
    apply_stimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 7, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // WAW on x9, with and without flush; a flushed long op changes nothing.
    apply_stimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 10, 1, 1, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Build outstanding=3 with x5 and x7 busy, reset, then a stale writeback.
    apply_stimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small register window so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      busy_list.delete();
      for (int r = 1; r < 8; r++) if (busy[r]) busy_list.push_back(r);
      if ((busy_list.size() > 0) && ($urandom_range(0, 99) < 70))
        wr = busy_list[$urandom_range(0, busy_list.size() - 1)];
      else
        wr = $urandom_range(0, 7);
      apply_stimulus($urandom_range(0, 99) < 80,
                     $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10,
                     $urandom_range(0, 99) < 50, wr, $urandom_range(0, 99) < 70);
    end

    @(posedge clock);
    #1;
    idle_inputs();
    repeat (2) @(negedge clock);
    #1;
    check_output("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
